ct_buffer_loader: RTL and testbench

Streams ciphertext limbs from the upstream polynomial stream into the 256-bank ciphertext buffer. Each accepted beat carries one row of `dp` coefficients and becomes one buffer write cycle. The block generates per-bank write addresses, write enable and an optional diagonal lane rotation, then reports completion. It sits directly upstream of the ciphertext buffer and drives its write port only.

---
 rtl/ct_pkg.sv | 30 +++
 rtl/ct_buffer_loader_lane_rotator.sv | 27 ++
 rtl/ct_buffer_loader.sv | 163 ++++++++++++++++
 tb/tb_ct_buffer_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_pkg.sv
// Shared parameters and types for the ciphertext buffer and the loader that fills it.
// The buffer and the loader both import this package so they agree on geometry.
package ct_pkg;

    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = 54;
    localparam int DP         = 256;
    localparam int LIMBS      = 4;
    localparam int ROWS       = 256;

    localparam int ROW_W  = $clog2(ROWS);
    localparam int LIMB_W = $clog2(LIMBS);
    localparam int NL_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } ld_state_t;

    typedef logic [ROW_W-1:0]  row_t;
    typedef logic [LIMB_W-1:0] limb_t;
    typedef logic [NL_W-1:0]   nlimb_t;

    // Requests above the buffer capacity load the full ciphertext instead.
    function automatic nlimb_t clamp_limbs(input nlimb_t req, input nlimb_t max_limbs);
        return (req > max_limbs) ? max_limbs : req;
    endfunction

endpackage

// File: rtl/ct_buffer_loader_lane_rotator.sv
// Combinational barrel rotate of LANES words: output lane b takes input lane (b - amount) mod LANES.
// LANES must be a power of two.
module lane_rotator #(
    parameter int LANES = ct_pkg::DP,
    parameter int WIDTH = ct_pkg::DATA_WIDTH,
    parameter int AMT_W = $clog2(LANES)
) (
    input  logic [LANES*WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0]       amount,
    output logic [LANES*WIDTH-1:0] data_out
);

    localparam int W = LANES * WIDTH;

    logic [W-1:0] stage [0:AMT_W];

    assign stage[0] = data_in;

    // Stage s rotates towards higher lanes by 2**s when amount[s] is set.
    for (genvar s = 0; s < AMT_W; s++) begin : g_stage
        localparam int SH = (1 << s) * WIDTH;
        assign stage[s+1] = amount[s] ? {stage[s][W-SH-1:0], stage[s][W-1 -: SH]} : stage[s];
    end

    assign data_out = stage[AMT_W];

endmodule

// File: rtl/ct_buffer_loader.sv
// Streams ciphertext rows into the banked ciphertext buffer: one accepted beat becomes one
// registered write with address {limb, row} on every bank and optional diagonal lane rotation.
module ct_buffer_loader #(
    parameter int ADDR_WIDTH = ct_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = ct_pkg::DATA_WIDTH,
    parameter int dp         = ct_pkg::DP,
    parameter int LIMBS      = ct_pkg::LIMBS,
    parameter int ROWS       = ct_pkg::ROWS,
    parameter int SKEW       = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [2:0]                 num_limbs,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [dp*DATA_WIDTH-1:0]   s_data,
    output logic                       buf_we,
    output logic [dp*ADDR_WIDTH-1:0]   buf_addr_write,
    output logic [dp*DATA_WIDTH-1:0]   buf_data_in,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 dbg_state
);

    import ct_pkg::*;

    localparam int RW = $clog2(ROWS);
    localparam int LW = (LIMBS > 1) ? $clog2(LIMBS) : 1;

    // Upstream handshake: a beat transfers on any rising edge where s_valid and s_ready are
    // both high. s_ready depends only on registered state, never on s_valid, and once the
    // final beat of a ciphertext is taken it is low on the following cycle.

    ld_state_t             state_q, state_d;
    logic [RW-1:0]         row_q;
    logic [LW-1:0]         limb_q;
    nlimb_t                nl_q;
    nlimb_t                start_nl;
    logic                  accept;
    logic                  last_beat;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [dp*DATA_WIDTH-1:0] lane_data;
    logic [dp*DATA_WIDTH-1:0] data_q;

    assign start_nl  = clamp_limbs(num_limbs, nlimb_t'(LIMBS));
    assign accept    = s_valid && s_ready;
    assign last_beat = (nlimb_t'(limb_q) == nl_q - nlimb_t'(1)) && (row_q == RW'(ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // A zero-limb request still reports completion, just without any write.
                if (start) begin
                    state_d = (start_nl == '0) ? ST_DRAIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept && last_beat) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            limb_q <= '0;
            nl_q   <= '0;
        end else if (state_q == ST_IDLE && start) begin
            row_q  <= '0;
            limb_q <= '0;
            nl_q   <= start_nl;
        end else if (accept) begin
            if (row_q == RW'(ROWS - 1)) begin
                row_q  <= '0;
                limb_q <= limb_q + LW'(1);
            end else begin
                row_q <= row_q + RW'(1);
            end
        end
    end

    generate
        if (SKEW != 0) begin : g_skew
            localparam int SW = $clog2(dp);
            logic [SW-1:0] rot_amt;

            // dp is a power of two, so keeping the low bits of row is row mod dp.
            assign rot_amt = SW'(row_q);

            lane_rotator #(
                .LANES (dp),
                .WIDTH (DATA_WIDTH),
                .AMT_W (SW)
            ) u_lane_rotator (
                .data_in  (s_data),
                .amount   (rot_amt),
                .data_out (lane_data)
            );
        end else begin : g_straight
            assign lane_data = s_data;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q <= accept;
            if (accept) begin
                addr_q <= ADDR_WIDTH'({limb_q, row_q});
                data_q <= lane_data;
            end
        end
    end

    for (genvar b = 0; b < dp; b++) begin : g_addr
        assign buf_addr_write[b*ADDR_WIDTH +: ADDR_WIDTH] = addr_q;
    end

    assign buf_we      = we_q;
    assign buf_data_in = data_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ct_buffer_loader.sv
// Directed bench for ct_buffer_loader: a straight-mapped and a skewed instance share one stream,
// every write is checked against the queue of beats the driver handed over.
`timescale 1ns/1ps
module tb_ct_buffer_loader;

    localparam int AW    = 10;
    localparam int DW    = 54;
    localparam int NB    = 256;
    localparam int LIMBS = 4;
    localparam int ROWS  = 256;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [2:0]        num_limbs;
    logic              s_valid;
    logic [NB*DW-1:0]  s_data;

    logic              s_ready0, s_ready1;
    logic              buf_we0, buf_we1;
    logic [NB*AW-1:0]  buf_addr_write0, buf_addr_write1;
    logic [NB*DW-1:0]  buf_data_in0, buf_data_in1;
    logic              busy0, busy1;
    logic              done0, done1;
    logic [1:0]        dbg_state0, dbg_state1;

    int n_checks  = 0;
    int n_errors  = 0;
    int write_cnt = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    int test_id   = 0;

    // Entry = {last beat of the load, global row index g = limb*ROWS + row}.
    logic [10:0] exp_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    ct_buffer_loader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .dp(NB), .LIMBS(LIMBS), .ROWS(ROWS), .SKEW(0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .num_limbs(num_limbs),
        .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
        .buf_we(buf_we0), .buf_addr_write(buf_addr_write0), .buf_data_in(buf_data_in0),
        .busy(busy0), .done(done0), .dbg_state(dbg_state0)
    );

    ct_buffer_loader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .dp(NB), .LIMBS(LIMBS), .ROWS(ROWS), .SKEW(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .num_limbs(num_limbs),
        .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
        .buf_we(buf_we1), .buf_addr_write(buf_addr_write1), .buf_data_in(buf_data_in1),
        .busy(busy1), .done(done1), .dbg_state(dbg_state1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Lane j of global row g carries g*1000 + j.
    function automatic logic [DW-1:0] exp_lane(input int g, input int bank, input bit skew);
        int row;
        int lane;
        row  = g % ROWS;
        lane = skew ? (((bank - row) % NB) + NB) % NB : bank;
        return DW'(g * 1000 + lane);
    endfunction

    // scoreboard
    logic [10:0] mon_e;
    int          mon_g;
    bit          mon_last;
    int          mon_a, mon_d0, mon_d1;

    always @(negedge clk) begin
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
        if (buf_we0 || buf_we1) begin
            check("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_e    = exp_q.pop_front();
                mon_g    = int'(mon_e[9:0]);
                mon_last = mon_e[10];
                write_cnt++;
                mon_a  = 0;
                mon_d0 = 0;
                mon_d1 = 0;
                for (int b = NB - 1; b >= 0; b--) begin
                    if (buf_addr_write0[b*AW +: AW] !== AW'(mon_g) ||
                        buf_addr_write1[b*AW +: AW] !== AW'(mon_g)) mon_a = b;
                    if (buf_data_in0[b*DW +: DW] !== exp_lane(mon_g, b, 1'b0)) mon_d0 = b;
                    if (buf_data_in1[b*DW +: DW] !== exp_lane(mon_g, b, 1'b1)) mon_d1 = b;
                end
                check("we_skew0", buf_we0, 1);
                check("we_skew1", buf_we1, 1);
                check("addr_skew0", buf_addr_write0[mon_a*AW +: AW], mon_g);
                check("addr_skew1", buf_addr_write1[mon_a*AW +: AW], mon_g);
                check("data_skew0", buf_data_in0[mon_d0*DW +: DW], exp_lane(mon_g, mon_d0, 1'b0));
                check("data_skew1", buf_data_in1[mon_d1*DW +: DW], exp_lane(mon_g, mon_d1, 1'b1));
                check("done_with_last0", done0, mon_last);
                check("done_with_last1", done1, mon_last);
                if (test_id == 2 && mon_g == 3) begin
                    check("skew_row3_bank5", buf_data_in1[5*DW +: DW], 3002);
                end
            end
        end
    end

    // drivers
    task automatic drive_row(input int g);
        for (int j = 0; j < NB; j++) begin
            s_data[j*DW +: DW] = DW'(g * 1000 + j);
        end
    endtask

    task automatic check_all_zero();
        check("rst_s_ready0", s_ready0, 0);
        check("rst_s_ready1", s_ready1, 0);
        check("rst_we0", buf_we0, 0);
        check("rst_we1", buf_we1, 0);
        check("rst_addr0", |buf_addr_write0, 0);
        check("rst_addr1", |buf_addr_write1, 0);
        check("rst_data0", |buf_data_in0, 0);
        check("rst_data1", |buf_data_in1, 0);
        check("rst_busy0", busy0, 0);
        check("rst_busy1", busy1, 0);
        check("rst_done0", done0, 0);
        check("rst_done1", done1, 0);
        check("rst_state0", dbg_state0, 0);
    endtask

    // Called at posedge+1 of an IDLE cycle; start is taken at the next rising edge.
    task automatic run_load(input int req, input int beats, input int gap,
                            input int mid_start, input int reset_at);
        int sent;
        int guard;
        int w_base;
        int d0_base;
        int d1_base;
        bit reset_hit;
        w_base    = write_cnt;
        d0_base   = done_cnt0;
        d1_base   = done_cnt1;
        sent      = 0;
        guard     = 0;
        reset_hit = 1'b0;
        start     = 1'b1;
        num_limbs = 3'(req);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start0", busy0, 1);
        check("busy_after_start1", busy1, 1);
        while (sent < beats && guard < 20000 && !reset_hit) begin
            start = (mid_start >= 0 && sent == mid_start);
            if (start) num_limbs = 3'd2;
            if (sent == reset_at) begin
                rst_n   = 1'b0;
                s_valid = 1'b0;
                start   = 1'b0;
                #1;
                check_all_zero();
                exp_q.delete();
                check("rst_partial_writes", write_cnt - w_base, sent - 1);
                check("rst_no_done0", done_cnt0 - d0_base, 0);
                check("rst_no_done1", done_cnt1 - d1_base, 0);
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
                check("post_rst_idle_busy", busy0, 0);
                check("post_rst_no_done", done_cnt0 - d0_base, 0);
                reset_hit = 1'b1;
            end else begin
                if (s_ready0 && $urandom_range(99) >= gap) begin
                    drive_row(sent);
                    s_valid = 1'b1;
                    exp_q.push_back({(sent == beats - 1), 10'(sent)});
                    sent++;
                end else begin
                    s_valid = 1'b0;
                end
                @(posedge clk); #1;
                guard++;
            end
        end
        s_valid = 1'b0;
        start   = 1'b0;
        if (!reset_hit) begin
            check("beats_sent", sent, beats);
            check("ready_drop0", s_ready0, 0);
            check("ready_drop1", s_ready1, 0);
            check("drain_done0", done0, 1);
            check("drain_busy0", busy0, 1);
            check("drain_state0", dbg_state0, 2);
            @(posedge clk); #1;
            check("idle_busy0", busy0, 0);
            check("idle_busy1", busy1, 0);
            check("idle_done0", done0, 0);
            check("queue_empty", exp_q.size(), 0);
            check("write_count", write_cnt - w_base, beats);
            check("done_count0", done_cnt0 - d0_base, 1);
            check("done_count1", done_cnt1 - d1_base, 1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        num_limbs = 3'd0;
        s_valid   = 1'b0;
        s_data    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero();
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ready_after_rst", s_ready0, 0);
        check("idle_busy_after_rst", busy0, 0);

        test_id = 1; run_load(1, 256, 0, -1, -1);
        test_id = 2; run_load(4, 1024, 0, -1, -1);
        test_id = 3; run_load(2, 512, 50, -1, -1);
        test_id = 4; run_load(0, 0, 0, -1, -1);
        test_id = 5; run_load(7, 1024, 0, -1, -1);
        test_id = 6; run_load(1, 256, 0, 50, -1);
        test_id = 7; run_load(4, 1024, 0, -1, 100);
        run_load(1, 256, 0, -1, -1);
        test_id = 8; run_load(2, 512, 0, -1, -1);
        run_load(1, 256, 0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
